varint_byte_streamer: RTL

Downstream stage of `varint_ser`. Accepts one 10-byte encoded varint per transaction, determines its encoded length from the continuation bits, and emits it as a byte stream, least-significant group first, with valid/ready flow control. It feeds the serialized-field byte path toward the message output buffer.

---
 rtl/varint_pkg.sv | 16 +
 rtl/varint_len.sv | 26 ++
 rtl/varint_byte_streamer.sv | 107 ++++++++++
 3 files changed

// File: rtl/varint_pkg.sv
// Shared types and constants for the varint byte path (serializer side and,
// later, the deserializer).
package varint_pkg;

  localparam int BYTE             = 8;
  localparam int VARINT_MAX_BYTES = 10;
  localparam int VARINT_IDX_W     = 4;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } varint_state_e;

  typedef logic [VARINT_MAX_BYTES-1:0][BYTE-1:0] varint_bytes_t;

endpackage

// File: rtl/varint_len.sv
// Encoded-length finder for a 10-byte varint: index of the first byte with a
// clear continuation bit, plus one. Purely combinational.
module varint_len
  import varint_pkg::*;
(
  input  logic [VARINT_MAX_BYTES*BYTE-1:0] word,
  output logic [VARINT_IDX_W-1:0]          len,
  output logic                             unterm
);

  // Scan from the top byte down so the lowest terminating byte wins.
  always_comb begin
    len    = 4'd10;
    unterm = 1'b1;
    for (int k = VARINT_MAX_BYTES - 1; k >= 0; k--) begin
      if (word[BYTE*k + 7] == 1'b0) begin
        len    = 4'(k + 1);
        unterm = 1'b0;
      end else begin
        len    = len;
        unterm = unterm;
      end
    end
  end

endmodule

// File: rtl/varint_byte_streamer.sv
// Streams one encoded varint (up to 10 bytes) out as bytes, least-significant
// group first, with valid/ready on both sides and no bubble between varints.
module varint_byte_streamer #(
  parameter int MAX_BYTES = 10,
  parameter int BYTE      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MAX_BYTES*BYTE-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BYTE-1:0]           out_byte,
  output logic                      out_last,
  output logic                      err_unterm
);
  import varint_pkg::*;

  varint_state_e                state_q, state_d;
  varint_bytes_t                hold_q, hold_d;
  logic [VARINT_IDX_W-1:0]      idx_q, idx_d;
  logic [VARINT_IDX_W-1:0]      len_q, len_d;
  logic                         unterm_q, unterm_d;

  logic [VARINT_IDX_W-1:0]      len_s;
  logic                         unterm_s;
  logic                         in_hs_s;
  logic                         out_hs_s;

  varint_len u_len (
    .word   (in_data),
    .len    (len_s),
    .unterm (unterm_s)
  );

  // Outputs are decoded purely from registered state and the holding register.
  assign out_valid  = (state_q == ST_STREAM);
  assign out_byte   = hold_q[idx_q];
  assign out_last   = out_valid && (idx_q == (len_q - 4'd1));
  assign err_unterm = out_valid && unterm_q;

  // Accepting on the last-byte handshake is what removes the inter-varint bubble.
  assign in_ready = (state_q == ST_IDLE) || (out_valid && out_ready && out_last);
  assign in_hs_s  = in_valid && in_ready;
  assign out_hs_s = out_valid && out_ready;

  // Next-state, index and holding-register update.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    idx_d    = idx_q;
    len_d    = len_q;
    unterm_d = unterm_q;
    case (state_q)
      ST_IDLE: begin
        if (in_hs_s) begin
          state_d  = ST_STREAM;
          hold_d   = in_data;
          idx_d    = 4'd0;
          len_d    = len_s;
          unterm_d = unterm_s;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (out_hs_s && out_last) begin
          if (in_hs_s) begin
            state_d  = ST_STREAM;
            hold_d   = in_data;
            idx_d    = 4'd0;
            len_d    = len_s;
            unterm_d = unterm_s;
          end else begin
            state_d  = ST_IDLE;
          end
        end else if (out_hs_s) begin
          idx_d = idx_q + 4'd1;
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset drops any partially streamed varint.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      hold_q   <= {VARINT_MAX_BYTES{8'h00}};
      idx_q    <= 4'd0;
      len_q    <= 4'd0;
      unterm_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      unterm_q <= unterm_d;
    end
  end

endmodule
